obi_varlat_arbiter_n_to_one: RTL and testbench



---
 rtl/obi_arb_pkg.sv | 26 ++
 rtl/obi_pkg.sv | 26 ++
 rtl/obi_arb_id_fifo.sv | 71 +++++++
 rtl/obi_varlat_arbiter_n_to_one.sv | 128 ++++++++++++
 tb/tb_obi_varlat_arbiter_n_to_one.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/obi_arb_pkg.sv
//------------------------------------------------------------------------------
// Module : obi_arb_pkg
// Brief  : Arbitration mode, FSM state encoding and index-width helper.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package obi_arb_pkg;

  typedef enum logic [0:0] {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/obi_pkg.sv
//------------------------------------------------------------------------------
// Module : obi_pkg
// Brief  : OBI request/response bundles shared by masters and the slave port.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

`default_nettype wire

// File: rtl/obi_arb_id_fifo.sv
//------------------------------------------------------------------------------
// Module : obi_arb_id_fifo
// Brief  : Response-routing ID FIFO; push and pop may coincide while full.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module obi_arb_id_fifo
  import obi_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int c_PTR_W = idx_width(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign empty_o   = (r_count == '0);
  assign full_o    = (r_count == c_CNT_W'(DEPTH));
  assign w_do_pop  = pop_i && !empty_o;
  // A pop frees the slot this cycle, so a full FIFO can still take a push.
  assign w_do_push = push_i && (!full_o || w_do_pop);
  assign rdata_o   = r_mem[r_rd_ptr];
  assign count_o   = r_count;

  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/obi_varlat_arbiter_n_to_one.sv
//------------------------------------------------------------------------------
// Module : obi_varlat_arbiter_n_to_one
// Brief  : N-to-1 OBI arbiter with request hold and ID-FIFO response routing.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module obi_varlat_arbiter_n_to_one
  import obi_pkg::*;
  import obi_arb_pkg::*;
#(
  parameter int NMASTER         = 3,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ARB_MODE        = 0
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  obi_req_t  [NMASTER-1:0]              master_req_i,
  output obi_resp_t [NMASTER-1:0]              master_resp_o,
  output obi_req_t                             slave_req_o,
  input  obi_resp_t                            slave_resp_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 proto_err_o
);

  localparam int        c_IDX_W = idx_width(NMASTER);
  localparam arb_mode_e c_MODE  = (ARB_MODE == 1) ? ARB_FIXED : ARB_RR;

  arb_state_e         r_state;
  arb_state_e         w_state_nxt;
  logic [c_IDX_W-1:0] r_hold_idx;
  logic [c_IDX_W-1:0] r_rr_ptr;
  logic               r_proto_err;

  logic [c_IDX_W-1:0] w_win_idx;
  logic               w_found;
  logic [c_IDX_W-1:0] w_sel_idx;
  logic               w_sel_valid;
  logic               w_hs;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_blocked;
  logic [c_IDX_W-1:0] w_head_idx;

  assign w_pop     = slave_resp_i.rvalid && !w_empty;
  assign w_blocked = w_full && !w_pop;

  // Round-robin rotates the search start; fixed priority always starts at 0.
  always_comb begin
    w_found   = 1'b0;
    w_win_idx = '0;
    for (int i = 0; i < NMASTER; i++) begin
      int j;
      j = (c_MODE == ARB_FIXED) ? i : (int'(r_rr_ptr) + i) % NMASTER;
      if (!w_found && !w_blocked && master_req_i[j].req) begin
        w_found   = 1'b1;
        w_win_idx = c_IDX_W'(j);
      end
    end
  end

  assign w_sel_idx   = (r_state == ST_HOLD) ? r_hold_idx : w_win_idx;
  assign w_sel_valid = (r_state == ST_HOLD) || w_found;
  assign w_hs        = !rst_i && w_sel_valid && slave_req_o.req && slave_resp_i.gnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_ARB;
      r_hold_idx  <= '0;
      r_rr_ptr    <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_ARB && w_found && !slave_resp_i.gnt) begin
        r_hold_idx <= w_win_idx;
      end
      if (w_hs) begin
        r_rr_ptr <= (w_sel_idx == c_IDX_W'(NMASTER - 1)) ? '0 : w_sel_idx + 1'b1;
      end
      if (slave_resp_i.rvalid && w_empty) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ARB:  if (w_found && !slave_resp_i.gnt) w_state_nxt = ST_HOLD;
      ST_HOLD: if (slave_resp_i.gnt) w_state_nxt = ST_ARB;
      default: w_state_nxt = ST_ARB;
    endcase
  end

  always_comb begin
    slave_req_o   = '0;
    master_resp_o = '0;
    if (!rst_i && w_sel_valid) begin
      slave_req_o                  = master_req_i[w_sel_idx];
      master_resp_o[w_sel_idx].gnt = slave_resp_i.gnt;
    end
    if (!rst_i && w_pop) begin
      master_resp_o[w_head_idx].rvalid = 1'b1;
      master_resp_o[w_head_idx].rdata  = slave_resp_i.rdata;
    end
  end

  obi_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (c_IDX_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_hs),
    .wdata_i (w_sel_idx),
    .pop_i   (w_pop),
    .rdata_o (w_head_idx),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (outstanding_o)
  );

  assign proto_err_o = r_proto_err;

endmodule

`default_nettype wire

// File: tb/tb_obi_varlat_arbiter_n_to_one.sv
//------------------------------------------------------------------------------
// Module : tb_obi_varlat_arbiter_n_to_one
// Brief  : Directed self-checking bench, round-robin and fixed-priority DUTs.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_obi_varlat_arbiter_n_to_one;
  import obi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  obi_req_t  [2:0] m_req, f_req;
  obi_resp_t [2:0] m_resp, f_resp;
  obi_req_t        s_req, fs_req;
  obi_resp_t       s_resp, fs_resp;
  logic [2:0]      outst, f_outst;
  logic            perr, f_perr;

  int checks   = 0;
  int failures = 0;

  obi_varlat_arbiter_n_to_one #(.NMASTER(3), .MAX_OUTSTANDING(4), .ARB_MODE(0)) u_dut_rr (
    .clk_i(clk), .rst_i(rst), .master_req_i(m_req), .master_resp_o(m_resp),
    .slave_req_o(s_req), .slave_resp_i(s_resp), .outstanding_o(outst), .proto_err_o(perr)
  );

  obi_varlat_arbiter_n_to_one #(.NMASTER(3), .MAX_OUTSTANDING(4), .ARB_MODE(1)) u_dut_fix (
    .clk_i(clk), .rst_i(rst), .master_req_i(f_req), .master_resp_o(f_resp),
    .slave_req_o(fs_req), .slave_resp_i(fs_resp), .outstanding_o(f_outst), .proto_err_o(f_perr)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] gv(input obi_resp_t [2:0] r);
    return {r[2].gnt, r[1].gnt, r[0].gnt};
  endfunction

  function automatic logic [2:0] rv(input obi_resp_t [2:0] r);
    return {r[2].rvalid, r[1].rvalid, r[0].rvalid};
  endfunction

  function automatic logic [31:0] maddr(input int i);
    return 32'h100 * (i + 1);
  endfunction

  function automatic obi_req_t [2:0] mk_req(input logic [2:0] mask);
    obi_req_t [2:0] r;
    for (int i = 0; i < 3; i++) begin
      r[i]       = '0;
      r[i].req   = mask[i];
      r[i].be    = 4'hF;
      r[i].addr  = maddr(i);
      r[i].wdata = 32'hC0 + i;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] mask, input logic gnt, input logic rvld, input logic [31:0] rd);
    m_req         = mk_req(mask);
    s_resp.gnt    = gnt;
    s_resp.rvalid = rvld;
    s_resp.rdata  = rd;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m_req = '0; f_req = '0; s_resp = '0; fs_resp = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sreq", s_req, '0);
    chk("rst_mresp", m_resp, '0);
    chk("rst_outst", outst, 3'd0);
    chk("rst_perr", perr, 1'b0);
    rst = 1'b0;
    step();

    // Round-robin fairness: grants 0,1,2,0,1,2 and rvalid two cycles later.
    for (int c = 0; c < 8; c++) begin
      drive((c < 6) ? 3'b111 : 3'b000, c < 6, c >= 2, 32'hD0 + c);
      if (c < 6) begin
        chk("rr_gnt", gv(m_resp), 3'b001 << (c % 3));
        chk("rr_addr", s_req.addr, maddr(c % 3));
      end
      if (c >= 2) begin
        chk("rr_rvalid", rv(m_resp), 3'b001 << ((c - 2) % 3));
        chk("rr_rdata", m_resp[(c - 2) % 3].rdata, 32'hD0 + c);
      end
      step();
    end
    drive(3'b000, 1'b0, 1'b0, 32'h0);
    chk("rr_outst_drained", outst, 3'd0);

    // Hold stability: master 1 held while master 0 also asks.
    drive(3'b010, 1'b0, 1'b0, 32'h0);
    chk("hold_addr0", s_req.addr, 32'h200);
    chk("hold_gnt0", gv(m_resp), 3'b000);
    step();
    for (int c = 1; c < 3; c++) begin
      drive(3'b011, 1'b0, 1'b0, 32'h0);
      chk("hold_addr", s_req.addr, 32'h200);
      chk("hold_gnt", gv(m_resp), 3'b000);
      step();
    end
    drive(3'b011, 1'b1, 1'b0, 32'h0);
    chk("hold_gnt_m1", gv(m_resp), 3'b010);
    chk("hold_addr_m1", s_req.addr, 32'h200);
    step();
    drive(3'b001, 1'b1, 1'b0, 32'h0);
    chk("hold_gnt_m0", gv(m_resp), 3'b001);
    chk("hold_addr_m0", s_req.addr, 32'h100);
    step();
    drive(3'b000, 1'b0, 1'b1, 32'h11);
    chk("hold_rv_m1", rv(m_resp), 3'b010);
    step();
    drive(3'b000, 1'b0, 1'b1, 32'h22);
    chk("hold_rv_m0", rv(m_resp), 3'b001);
    step();

    // Variable latency: m0 answered after 1 cycle, m1 after 5.
    drive(3'b001, 1'b1, 1'b0, 32'h0);
    chk("ooo_gnt_m0", gv(m_resp), 3'b001);
    chk("ooo_addr_m0", s_req.addr, 32'h100);
    step();
    drive(3'b010, 1'b1, 1'b1, 32'hA);
    chk("ooo_gnt_m1", gv(m_resp), 3'b010);
    chk("ooo_addr_m1", s_req.addr, 32'h200);
    chk("ooo_rv_m0", rv(m_resp), 3'b001);
    chk("ooo_rdata_m0", m_resp[0].rdata, 32'hA);
    step();
    for (int c = 2; c < 6; c++) begin
      drive(3'b000, 1'b0, 1'b0, 32'h0);
      chk("ooo_rv_idle", rv(m_resp), 3'b000);
      step();
    end
    drive(3'b000, 1'b0, 1'b1, 32'hB);
    chk("ooo_rv_m1", rv(m_resp), 3'b010);
    chk("ooo_rdata_m1", m_resp[1].rdata, 32'hB);
    chk("ooo_rdata_m0_quiet", m_resp[0].rdata, 32'h0);
    step();

    // Outstanding limit: four grants, then stall, then push+pop while full.
    for (int c = 0; c < 4; c++) begin
      drive(3'b111, 1'b1, 1'b0, 32'h0);
      chk("lim_gnt", gv(m_resp), 3'b001 << ((2 + c) % 3));
      step();
    end
    drive(3'b111, 1'b1, 1'b0, 32'h0);
    chk("lim_stall_req", s_req.req, 1'b0);
    chk("lim_stall_gnt", gv(m_resp), 3'b000);
    chk("lim_outst_full", outst, 3'd4);
    step();
    drive(3'b111, 1'b1, 1'b1, 32'h55);
    chk("lim_pushpop_gnt", gv(m_resp), 3'b001);
    chk("lim_pushpop_rv", rv(m_resp), 3'b100);
    chk("lim_pushpop_req", s_req.req, 1'b1);
    step();
    drive(3'b000, 1'b0, 1'b0, 32'h0);
    chk("lim_outst_still4", outst, 3'd4);
    for (int k = 0; k < 4; k++) begin
      drive(3'b000, 1'b0, 1'b1, 32'h60 + k);
      chk("lim_drain_rv", rv(m_resp), 3'b001 << (k % 3));
      step();
    end
    drive(3'b000, 1'b0, 1'b0, 32'h0);
    chk("lim_outst_empty", outst, 3'd0);

    // Protocol error and asynchronous reset mid-transaction.
    drive(3'b000, 1'b0, 1'b1, 32'h77);
    chk("err_rv_dropped", rv(m_resp), 3'b000);
    chk("err_perr_before", perr, 1'b0);
    step();
    drive(3'b000, 1'b0, 1'b0, 32'h0);
    chk("err_perr_set", perr, 1'b1);
    for (int c = 0; c < 2; c++) begin
      drive(3'b001, 1'b1, 1'b0, 32'h0);
      step();
    end
    drive(3'b000, 1'b0, 1'b0, 32'h0);
    chk("err_outst2", outst, 3'd2);
    #1 rst = 1'b1;
    #1;
    chk("err_rst_outst", outst, 3'd0);
    chk("err_rst_perr", perr, 1'b0);
    step();
    rst = 1'b0;
    step();
    drive(3'b000, 1'b0, 1'b1, 32'h88);
    chk("err_post_rst_rv", rv(m_resp), 3'b000);
    step();
    drive(3'b000, 1'b0, 1'b0, 32'h0);
    chk("err_post_rst_perr", perr, 1'b1);

    // Fixed priority: master 0 beats master 2 until it drops its request.
    for (int c = 0; c < 6; c++) begin
      f_req          = mk_req((c < 4) ? 3'b101 : ((c == 4) ? 3'b100 : 3'b000));
      fs_resp.gnt    = (c < 5);
      fs_resp.rvalid = (c >= 1);
      fs_resp.rdata  = 32'hE0 + c;
      #1;
      if (c < 4) begin
        chk("fix_gnt_m0", gv(f_resp), 3'b001);
        chk("fix_addr_m0", fs_req.addr, 32'h100);
      end
      if (c == 4) begin
        chk("fix_gnt_m2", gv(f_resp), 3'b100);
        chk("fix_addr_m2", fs_req.addr, 32'h300);
      end
      if (c >= 1) begin
        chk("fix_rv", rv(f_resp), (c == 5) ? 3'b100 : 3'b001);
      end
      step();
    end
    f_req = '0; fs_resp = '0;
    #1;
    chk("fix_outst_empty", f_outst, 3'd0);
    chk("fix_perr", f_perr, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
